gate_exerciser: RTL and testbench
=================================

Name: gate_exerciser

Overview:
Self-checking stimulus and response engine for any 2-input combinational gate.
- On a start request it drives the four input combinations onto the gate's in1/in2.
- After each vector it holds for a settle period, then samples the gate's out1 and compares it with a parameterised expected truth table.
- It reports an error count, the first failing vector, and pass/done status.
- It is the driving/checking end of the gate interface and lets gate examples be verified in hardware as well as in simulation.

Parameters:
HOLD_CYCLES, 4, clock cycles each vector is held before out1 is sampled; legal range 1..255.
EXPECTED_TT, 4'b1000, expected out1 per vector; bit index = {in1,in2} (default = AND).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  run request, sampled in IDLE or DONE only
dut_out  input  1  gate output (out1 of the gate under test)
in1  output  1  gate input 1 = vector bit 1
in2  output  1  gate input 2 = vector bit 0
busy  output  1  high while a run is in progress
done  output  1  high from run completion until next start
pass  output  1  valid when done; 1 = zero mismatches
err_count  output  3  mismatch count, 0..4, no saturation needed
first_err_valid  output  1  at least one mismatch recorded this run
first_err_vec  output  2  {in1,in2} of the first mismatch

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. All outputs 0; internal vec and hold counter 0. Reset mid-run aborts immediately and returns to IDLE with results cleared.
- States: IDLE, DRIVE, DONE. All outputs are registered.
- IDLE: in1=in2=0, busy=0, done=0.
  - If start=1 at edge T: go to DRIVE at T+1 with vec=0, hold=0, and clear err_count, first_err_valid, first_err_vec and pass.
- DRIVE: busy=1; {in1,in2}=vec.
  - Each cycle with hold<HOLD_CYCLES-1: hold++.
  - On the cycle with hold==HOLD_CYCLES-1: sample dut_out.
    - Mismatch vs EXPECTED_TT[vec]: err_count++.
    - If first_err_valid=0 on a mismatch: first_err_vec=vec, first_err_valid=1.
    - If vec==3: go to DONE.
    - Otherwise: vec++, hold=0. The new vector appears on in1/in2 the next cycle.
  - Vector order is 00, 01, 10, 11.
- Timing: vector k is driven from T+1+k*HOLD_CYCLES, sampled at edge T+(k+1)*HOLD_CYCLES. done rises at T+4*HOLD_CYCLES+1.
- DONE: busy=0, done=1, in1=in2=0.
  - pass = (err_count==0) including the final sample's result; it settles together with done.
  - Results hold until start=1, which restarts exactly as from IDLE (same cycle timing, results cleared).
- start while in DRIVE is ignored.
- dut_out is treated as synchronous to clk and is not resynchronised. The gate under test must settle within HOLD_CYCLES-1 cycles.
- err_count is 3 bits; the maximum is 4, so no wrap is possible.

Test Plan:
1. Correct AND gate, defaults, start pulse at edge T -> {in1,in2} steps 00,01,10,11, each held 4 cycles. done=1 at T+17, pass=1, err_count=0, first_err_valid=0.
2. AND gate as DUT with EXPECTED_TT=4'b1110 (OR table) -> mismatches at 01 and 10: err_count=2, first_err_vec=2'b01, first_err_valid=1, pass=0.
3. dut_out tied to 1, defaults -> mismatches at 00, 01, 10: err_count=3, first_err_vec=2'b00, pass=0.
4. HOLD_CYCLES=1, AND gate, start at T -> vectors change every cycle, done at T+5, pass=1. A second start in DONE gives an identical trace, with results cleared at T'+1.
5. start re-pulsed during DRIVE -> no effect: sequence and done time unchanged, busy stays high. rst_n pulled low during vector 2 -> in1=in2=0, busy=0, err_count=0 immediately (asynchronously), state IDLE.

Source files
------------

// File: rtl/gate_exerciser.sv
// Stimulus/response engine for a 2-input combinational gate: walks the four input
// vectors, samples the gate after a settle period and scores it against a truth table.
module gate_exerciser #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [3:0]  EXPECTED_TT = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic       first_err_valid,
    output logic [1:0] first_err_vec
);

    // Handshake: start is a level request sampled on any rising edge while not
    // busy; done/pass/err_* stay stable from completion until the next accepted start.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state, state_nx;
    logic [1:0] vec, vec_nx;
    logic [7:0] hold, hold_nx;
    logic       in1_nx, in2_nx, busy_nx, done_nx, pass_nx;
    logic [2:0] err_count_nx;
    logic       first_err_valid_nx;
    logic [1:0] first_err_vec_nx;
    logic       sample;
    logic       mismatch;

    assign sample   = (hold == HOLD_LAST);
    assign mismatch = (dut_out != EXPECTED_TT[vec]);

    always_comb begin
        state_nx           = state;
        vec_nx             = vec;
        hold_nx            = hold;
        in1_nx             = in1;
        in2_nx             = in2;
        busy_nx            = busy;
        done_nx            = done;
        pass_nx            = pass;
        err_count_nx       = err_count;
        first_err_valid_nx = first_err_valid;
        first_err_vec_nx   = first_err_vec;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx           = DRIVE;
                    vec_nx             = 2'd0;
                    hold_nx            = 8'd0;
                    in1_nx             = 1'b0;
                    in2_nx             = 1'b0;
                    busy_nx            = 1'b1;
                    done_nx            = 1'b0;
                    pass_nx            = 1'b0;
                    err_count_nx       = 3'd0;
                    first_err_valid_nx = 1'b0;
                    first_err_vec_nx   = 2'd0;
                end
            end
            DRIVE: begin
                if (!sample) begin
                    hold_nx = hold + 8'd1;
                end else begin
                    if (mismatch) begin
                        err_count_nx = err_count + 3'd1;
                        if (!first_err_valid) begin
                            first_err_valid_nx = 1'b1;
                            first_err_vec_nx   = vec;
                        end
                    end
                    hold_nx = 8'd0;
                    if (vec == 2'd3) begin
                        // Final verdict includes the sample taken on this very edge.
                        state_nx = DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        in1_nx   = 1'b0;
                        in2_nx   = 1'b0;
                        pass_nx  = (err_count == 3'd0) && !mismatch;
                    end else begin
                        vec_nx = vec + 2'd1;
                        {in1_nx, in2_nx} = vec + 2'd1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            vec             <= 2'd0;
            hold            <= 8'd0;
            in1             <= 1'b0;
            in2             <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 3'd0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 2'd0;
        end else begin
            state           <= state_nx;
            vec             <= vec_nx;
            hold            <= hold_nx;
            in1             <= in1_nx;
            in2             <= in2_nx;
            busy            <= busy_nx;
            done            <= done_nx;
            pass            <= pass_nx;
            err_count       <= err_count_nx;
            first_err_valid <= first_err_valid_nx;
            first_err_vec   <= first_err_vec_nx;
        end
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// Bench for gate_exerciser: three instances (default, OR expectation, 1-cycle hold)
// each driving a truth-table gate model; traces are predicted cycle by cycle.
module tb_gate_exerciser;

    logic clk;
    logic rst_n;
    logic       start_r   [3];
    logic [3:0] gate_tt   [3];
    logic       gate_out  [3];
    logic       in1_w     [3];
    logic       in2_w     [3];
    logic       busy_w    [3];
    logic       done_w    [3];
    logic       pass_w    [3];
    logic [2:0] err_w     [3];
    logic       fev_w     [3];
    logic [1:0] fvec_w    [3];

    int         hold_of [3] = '{4, 4, 1};
    logic [3:0] ett_of  [3] = '{4'b1000, 4'b1110, 4'b1000};

    int checks_total  = 0;
    int checks_passed = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // gate under test: arbitrary truth table indexed by {in1,in2}
    for (genvar g = 0; g < 3; g++) begin : g_gate
        assign gate_out[g] = gate_tt[g][{in1_w[g], in2_w[g]}];
    end

    gate_exerciser dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .dut_out(gate_out[0]),
        .in1(in1_w[0]), .in2(in2_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .err_count(err_w[0]), .first_err_valid(fev_w[0]),
        .first_err_vec(fvec_w[0])
    );

    gate_exerciser #(.HOLD_CYCLES(4), .EXPECTED_TT(4'b1110)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .dut_out(gate_out[1]),
        .in1(in1_w[1]), .in2(in2_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .err_count(err_w[1]), .first_err_valid(fev_w[1]),
        .first_err_vec(fvec_w[1])
    );

    gate_exerciser #(.HOLD_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_r[2]), .dut_out(gate_out[2]),
        .in1(in1_w[2]), .in2(in2_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .err_count(err_w[2]), .first_err_valid(fev_w[2]),
        .first_err_vec(fvec_w[2])
    );

    // Pulses start on instance d and predicts every cycle of the run from the
    // schedule: vector k visible for cycles k*h+1..(k+1)*h, its verdict visible
    // from cycle (k+1)*h+1. Optionally re-pulses start or asserts reset mid-run.
    task automatic run_check(input int d, input logic [3:0] gtt, input int repulse_c,
                             input int abort_c, input string name);
        int         h;
        logic [3:0] mism;
        int         n_samp;
        int         exp_err;
        logic       exp_fev;
        logic [1:0] exp_fvec;
        logic [1:0] exp_vec;
        logic       in_run;
        h = hold_of[d];
        gate_tt[d] = gtt;
        mism = gtt ^ ett_of[d];
        @(negedge clk);
        start_r[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= 4 * h + 2; c++) begin
            start_r[d] = (c == repulse_c);
            if (c == abort_c) begin
                #1 rst_n = 1'b0;
                #1;
                checks_total++;
                if ({in1_w[d], in2_w[d], busy_w[d], done_w[d], pass_w[d], err_w[d], fev_w[d], fvec_w[d]} !== 10'd0)
                    $display("FAIL %s abort_clear: in=%b%b busy=%b done=%b pass=%b err=%0d fev=%b fvec=%b, all required 0",
                             name, in1_w[d], in2_w[d], busy_w[d], done_w[d], pass_w[d], err_w[d], fev_w[d], fvec_w[d]);
                else checks_passed++;
                start_r[d] = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                checks_total++;
                if ({busy_w[d], done_w[d], in1_w[d], in2_w[d]} !== 4'b0000)
                    $display("FAIL %s abort_idle: busy=%b done=%b in=%b%b, required idle zeros",
                             name, busy_w[d], done_w[d], in1_w[d], in2_w[d]);
                else checks_passed++;
                return;
            end
            n_samp = (c - 1) / h;
            if (n_samp > 4) n_samp = 4;
            exp_err = 0;
            exp_fev = 1'b0;
            exp_fvec = 2'd0;
            for (int k = 0; k < n_samp; k++) begin
                if (mism[k]) begin
                    exp_err++;
                    if (!exp_fev) begin
                        exp_fev = 1'b1;
                        exp_fvec = 2'(k);
                    end
                end
            end
            in_run = (c <= 4 * h);
            exp_vec = in_run ? 2'((c - 1) / h) : 2'd0;

            checks_total++;
            if ({in1_w[d], in2_w[d]} !== exp_vec)
                $display("FAIL %s vec c=%0d: got %b%b required %b", name, c, in1_w[d], in2_w[d], exp_vec);
            else checks_passed++;
            checks_total++;
            if (busy_w[d] !== in_run || done_w[d] !== !in_run)
                $display("FAIL %s busy_done c=%0d: got busy=%b done=%b required busy=%b done=%b",
                         name, c, busy_w[d], done_w[d], in_run, !in_run);
            else checks_passed++;
            checks_total++;
            if (err_w[d] !== 3'(exp_err))
                $display("FAIL %s err_count c=%0d: got %0d required %0d", name, c, err_w[d], exp_err);
            else checks_passed++;
            checks_total++;
            if (fev_w[d] !== exp_fev || fvec_w[d] !== exp_fvec)
                $display("FAIL %s first_err c=%0d: got valid=%b vec=%b required valid=%b vec=%b",
                         name, c, fev_w[d], fvec_w[d], exp_fev, exp_fvec);
            else checks_passed++;
            checks_total++;
            if (pass_w[d] !== (!in_run && exp_err == 0))
                $display("FAIL %s pass c=%0d: got %b required %b", name, c, pass_w[d], (!in_run && exp_err == 0));
            else checks_passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            start_r[d] = 1'b0;
            gate_tt[d] = 4'b1000;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks_total++;
            if ({in1_w[d], in2_w[d], busy_w[d], done_w[d], pass_w[d], err_w[d], fev_w[d], fvec_w[d]} !== 10'd0)
                $display("FAIL reset dut%0d: in=%b%b busy=%b done=%b pass=%b err=%0d fev=%b fvec=%b, all required 0",
                         d, in1_w[d], in2_w[d], busy_w[d], done_w[d], pass_w[d], err_w[d], fev_w[d], fvec_w[d]);
            else checks_passed++;
        end
    endtask

    task automatic test_and_default();
        run_check(0, 4'b1000, 0, 0, "and_default");
    endtask

    task automatic test_or_table();
        run_check(1, 4'b1000, 0, 0, "or_table");
    endtask

    task automatic test_tied_high();
        run_check(0, 4'b1111, 0, 0, "tied_high");
    endtask

    task automatic test_back_to_back();
        run_check(2, 4'b1000, 0, 0, "hold1_first");
        run_check(2, 4'b0111, 0, 0, "hold1_errs");
        run_check(2, 4'b1000, 0, 0, "hold1_restart");
    endtask

    task automatic test_start_during_drive();
        run_check(0, 4'b0110, 6, 0, "repulse");
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            run_check(int'($urandom_range(0, 2)), 4'($urandom_range(0, 15)), 0, 0, "random");
        end
    endtask

    task automatic test_reset_mid_run();
        run_check(0, 4'b1111, 0, 10, "reset_mid_run");
        run_check(0, 4'b1000, 0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_and_default();
        test_or_table();
        test_tied_high();
        test_back_to_back();
        test_start_during_drive();
        test_random();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
